// File: rtl/fft_pkg.sv
// Shared constants for the 16-point FFT path: sizes, first-stage
// twiddles in Q16 and the ping-pong bank state encoding.
package fft_pkg;

  localparam int N      = 16;
  localparam int HALF   = N / 2;
  localparam int CPLX_W = 32;
  localparam int TW_W   = 20;

  // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), k = 0..7
  localparam logic [TW_W-1:0] TW_RE [HALF] = '{
    20'h10000, 20'h0EC83, 20'h0B505, 20'h061F8,
    20'h00000, 20'hF9E08, 20'hF4AFB, 20'hF137D
  };

  localparam logic [TW_W-1:0] TW_IM [HALF] = '{
    20'h00000, 20'hF9E08, 20'hF4AFB, 20'hF137D,
    20'hF0000, 20'hF137D, 20'hF4AFB, 20'hF9E08
  };

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_t;

endpackage

// File: rtl/fft_twiddle_rom.sv
// First-stage twiddle lookup for the 16-point FFT.
// Combinational; shared with downstream stage controllers.
module fft_twiddle_rom
  import fft_pkg::*;
(
  input  logic [2:0]      k,
  output logic [TW_W-1:0] w_real,
  output logic [TW_W-1:0] w_image
);

  assign w_real  = TW_RE[k];
  assign w_image = TW_IM[k];

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer feeding first-stage butterfly pairs.
// Optional sticky drop flag: define FFT_BUF_OVF_EN.
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int N     = 16,
  parameter int DIN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DIN_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CPLX_W-1:0] X,
  output logic [CPLX_W-1:0] Y,
  output logic [TW_W-1:0]   W_real,
  output logic [TW_W-1:0]   W_image,
  output logic [2:0]        pair_idx,
  output logic              frame_last
`ifdef FFT_BUF_OVF_EN
  ,
  output logic              ovf
`endif
);

  logic [DIN_W-1:0] mem [2][N];
  bank_st_t bank_st [2];

  logic       wr_bank;
  logic       rd_bank;
  logic [3:0] wr_cnt;
  logic       stall;

  logic       wr_en;
  logic       wr_sel;
  logic [3:0] wr_addr;

  logic       xfer;
  logic       xfer_last;
  logic       ld_en;
  logic       ld_bank;
  logic [2:0] ld_k;
  logic [TW_W-1:0] ld_wr;
  logic [TW_W-1:0] ld_wi;

  // A stalled writer always resumes in the other bank so frames
  // leave in the order they were collected.
  always_comb begin
    wr_en   = in_valid && (!stall || bank_st[!wr_bank] == EMPTY);
    wr_sel  = stall ? !wr_bank : wr_bank;
    wr_addr = stall ? 4'd0 : wr_cnt;
  end

  always_comb begin
    xfer      = out_valid && out_ready;
    xfer_last = xfer && pair_idx == 3'd7;
    ld_en     = 1'b0;
    ld_bank   = rd_bank;
    ld_k      = 3'd0;
    unique case (1'b1)
      (!out_valid && bank_st[rd_bank] == FULL): begin
        ld_en = 1'b1;
      end
      (xfer && !xfer_last): begin
        ld_en = 1'b1;
        ld_k  = pair_idx + 3'd1;
      end
      (xfer_last && bank_st[!rd_bank] == FULL): begin
        ld_en   = 1'b1;
        ld_bank = !rd_bank;
      end
      default: ;
    endcase
  end

  fft_twiddle_rom u_rom (
    .k      (ld_k),
    .w_real (ld_wr),
    .w_image(ld_wi)
  );

  always_ff @(posedge clk) begin
    if (rst_n && wr_en)
      mem[wr_sel][wr_addr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= 4'd0;
      stall      <= 1'b0;
      out_valid  <= 1'b0;
      X          <= '0;
      Y          <= '0;
      W_real     <= '0;
      W_image    <= '0;
      pair_idx   <= 3'd0;
      frame_last <= 1'b0;
    end else begin
      if (wr_en) begin
        if (stall) begin
          stall             <= 1'b0;
          wr_bank           <= !wr_bank;
          wr_cnt            <= 4'd1;
          bank_st[!wr_bank] <= FILLING;
        end else if (wr_cnt == 4'(N - 1)) begin
          bank_st[wr_bank] <= FULL;
          wr_cnt           <= 4'd0;
          if (bank_st[!wr_bank] == EMPTY)
            wr_bank <= !wr_bank;
          else
            stall <= 1'b1;
        end else begin
          bank_st[wr_bank] <= FILLING;
          wr_cnt           <= wr_cnt + 4'd1;
        end
      end

      if (ld_en) begin
        out_valid  <= 1'b1;
        X          <= {mem[ld_bank][{1'b0, ld_k}], 16'h0000};
        Y          <= {mem[ld_bank][{1'b1, ld_k}], 16'h0000};
        W_real     <= ld_wr;
        W_image    <= ld_wi;
        pair_idx   <= ld_k;
        frame_last <= (ld_k == 3'd7);
        if (ld_k == 3'd0)
          bank_st[ld_bank] <= DRAINING;
      end else if (xfer) begin
        out_valid  <= 1'b0;
        frame_last <= 1'b0;
      end

      if (xfer_last) begin
        bank_st[rd_bank] <= EMPTY;
        rd_bank          <= !rd_bank;
      end
    end
  end

`ifdef FFT_BUF_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (in_valid && !wr_en)
      ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench for fft_input_buffer: frame-level reference
// model, randomized data and handshakes.
module tb_fft_input_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [31:0] X;
  logic [31:0] Y;
  logic [19:0] W_real;
  logic [19:0] W_image;
  logic [2:0]  pair_idx;
  logic        frame_last;
`ifdef FFT_BUF_OVF_EN
  logic        ovf;
`endif

  fft_input_buffer #(.N(16), .DIN_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X         (X),
    .Y         (Y),
    .W_real    (W_real),
    .W_image   (W_image),
    .pair_idx  (pair_idx),
    .frame_last(frame_last)
`ifdef FFT_BUF_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [19:0] wr;
    logic [19:0] wi;
    logic [2:0]  k;
    logic        last;
  } pair_t;

  pair_t       expq[$];
  logic [15:0] part[$];
  int          held = 0;
  int          xfers = 0;
  bit          exp_ovf = 1'b0;
  int          passed = 0;
  int          total = 0;

  function automatic void chk(bit ok, string nm,
                              logic [127:0] got, logic [127:0] want);
    total++;
    if (ok) passed++;
    else $display("FAIL %s got=%h want=%h", nm, got, want);
  endfunction

  function automatic int q16(real v);
    real s;
    s = v * 65536.0;
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
  endfunction

  function automatic pair_t mk(int k, logic [15:0] a, logic [15:0] b);
    pair_t p;
    real ang;
    ang    = 2.0 * 3.14159265358979 * real'(k) / 16.0;
    p.x    = {a, 16'h0000};
    p.y    = {b, 16'h0000};
    p.wr   = 20'(q16($cos(ang)));
    p.wi   = 20'(q16(-$sin(ang)));
    p.k    = 3'(k);
    p.last = (k == 7);
    return p;
  endfunction

  // Reference: a frame can be started only while fewer than two
  // completed frames are still waiting or draining.
  always @(negedge clk) begin
    if (!rst_n) begin
      part.delete();
      expq.delete();
      held    = 0;
      xfers   = 0;
      exp_ovf = 1'b0;
    end else begin
      if (in_valid) begin
        if (part.size() != 0 || held < 2) begin
          part.push_back(in_data);
          if (part.size() == 16) begin
            for (int k = 0; k < 8; k++)
              expq.push_back(mk(k, part[k], part[k + 8]));
            part.delete();
            held++;
          end
        end else begin
          exp_ovf = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        xfers++;
        if (xfers == 8) begin
          xfers = 0;
          held--;
        end
      end
    end
  end

  pair_t prev;
  bit    hold_pend = 1'b0;

  always @(negedge clk) begin
    pair_t cur;
    pair_t e;
    cur = {X, Y, W_real, W_image, pair_idx, frame_last};
    if (rst_n && hold_pend)
      chk(out_valid === 1'b1 && cur == prev, "hold", cur, prev);
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk(1'b0, "unexpected_pair", cur, 0);
      end else begin
        e = expq.pop_front();
        chk(cur == e, "pair", cur, e);
      end
    end
    hold_pend = rst_n && out_valid && !out_ready;
    prev      = cur;
  end

  task automatic tick(bit v, logic [15:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_zero(string nm);
    chk({out_valid, X, Y, W_real, W_image, pair_idx, frame_last} == 0,
        nm, {out_valid, X, Y, W_real, W_image, pair_idx, frame_last}, 0);
`ifdef FFT_BUF_OVF_EN
    chk(ovf === 1'b0, {nm, "_ovf"}, ovf, 0);
`endif
  endtask

  initial begin
    bit found;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) tick(1'b1, 16'(i));
    chk(out_valid === 1'b0, "lat_pre", out_valid, 0);
    @(posedge clk);
    #1;
    chk(out_valid === 1'b1 && pair_idx == 3'd0 && X == 32'h00010000,
        "lat_k0", {out_valid, pair_idx, X}, {1'b1, 3'd0, 32'h00010000});
    repeat (12) tick(1'b0, 16'h0);

    for (int i = 0; i < 16; i++)
      tick(1'b1, i == 0 ? 16'h8000 : i == 8 ? 16'h7FFF : 16'($urandom));
    @(posedge clk);
    #1;
    chk(X == 32'h80000000 && Y == 32'h7FFF0000 && W_real == 20'h10000,
        "pair_8000", {X, Y, W_real}, {32'h80000000, 32'h7FFF0000, 20'h10000});
    repeat (12) tick(1'b0, 16'h0);

    for (int i = 0; i < 16; i++) tick(1'b1, 16'($urandom));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && pair_idx == 3'd3) found = 1'b1;
      else tick(1'b0, 16'h0);
    end
    chk(found, "bp_reach_k3", found, 1);
    out_ready = 1'b0;
    repeat (5) tick(1'b0, 16'h0);
    out_ready = 1'b1;
    repeat (10) tick(1'b0, 16'h0);

    for (int i = 0; i < 48; i++) tick(1'b1, 16'($urandom));
    repeat (12) tick(1'b0, 16'h0);
`ifdef FFT_BUF_OVF_EN
    chk(ovf === 1'b0, "stream_ovf", ovf, 0);
`endif

    out_ready = 1'b0;
    for (int i = 0; i < 33; i++) tick(1'b1, 16'($urandom));
`ifdef FFT_BUF_OVF_EN
    chk(ovf === 1'b1, "drop_ovf", ovf, 1);
`endif
    out_ready = 1'b1;
    repeat (20) tick(1'b0, 16'h0);
    for (int i = 0; i < 16; i++) tick(1'b1, 16'($urandom));
    repeat (12) tick(1'b0, 16'h0);

    for (int i = 0; i < 10; i++) tick(1'b1, 16'($urandom));
    rst_n = 1'b0;
    tick(1'b0, 16'h0);
    chk_zero("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) tick(1'b1, 16'($urandom));
    repeat (12) tick(1'b0, 16'h0);

    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom % 3) != 0;
      tick(($urandom % 4) != 0, 16'($urandom));
    end

    out_ready = 1'b1;
    for (int i = 0; i < 100 && expq.size() != 0; i++) tick(1'b0, 16'h0);
    chk(expq.size() == 0, "drain", expq.size(), 0);
`ifdef FFT_BUF_OVF_EN
    chk(ovf === exp_ovf, "final_ovf", ovf, exp_ovf);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
